s386_bist_ctrl: RTL and testbench
=================================

Name: s386_bist_ctrl

Overview:
- Built-in self-test sequencer for the s386w benchmark core (7 primary inputs, 7 primary outputs, 6 internal flip-flops).
- Initialises the core by flushing constant inputs through it, then applies LFSR pseudo-random patterns to its inputs.
- Compacts the core's outputs into a MISR signature and compares the final signature against a golden value.
- Sits beside the core in the benchmark testbench wrapper and shares the core's CLOCK.

Parameters:
- PAT_CNT, 255: number of RUN patterns applied; legal range 1..65535; 16-bit counter.
- FLUSH_CYC, 8: FLUSH cycles with all-zero inputs; legal range 1..255.
- LFSR_SEED, 16'hACE1: LFSR reset/restart value; must be nonzero.
- MISR_SEED, 16'h0000: MISR reset/restart value.
- GOLDEN, 16'h0000: expected final signature.

Ports:
- CLOCK  in  1  single clock, rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- start  in  1  level-sampled; starts a run from IDLE or DONE.
- abort  in  1  returns the block to IDLE from any state except IDLE.
- cut_pi  out  7  drives core inputs {v6,v5,v4,v3,v2,v1,v0}; bit0 = v0.
- cut_po  in  7  core outputs {v13_D_12..v13_D_6}; bit0 = v13_D_6.
- busy  out  1  high in FLUSH, RUN and COMPARE.
- done  out  1  high in DONE.
- pass  out  1  valid while done=1.
- signature  out  16  current MISR contents.
- pat_idx  out  16  number of patterns applied in the current run.

Behaviour:
- Clocking and reset: one clock (CLOCK); RESET_N is asynchronous, active-low.
- Reset values:
  - state = IDLE
  - cut_pi = 0, busy = 0, done = 0, pass = 0, pat_idx = 0
  - lfsr = LFSR_SEED, misr = MISR_SEED
  - signature = MISR_SEED
- States: IDLE, FLUSH, RUN, COMPARE, DONE. Encoding is free.
- IDLE:
  - start=1 -> FLUSH.
  - On entry to FLUSH: flush counter = FLUSH_CYC, lfsr = LFSR_SEED, misr = MISR_SEED, pat_idx = 0, done = 0, pass = 0.
- FLUSH:
  - cut_pi = 0.
  - Counter decrements each cycle; after FLUSH_CYC cycles -> RUN.
  - MISR is not updated.
- RUN:
  - cut_pi = lfsr[6:0], combinationally from the registered lfsr.
  - The core is treated as combinational from cut_pi to cut_po within the cycle; capture happens at the closing edge of each RUN cycle.
  - At each RUN edge:
    - lfsr <= {fb(lfsr), lfsr[15:1]}
    - misr <= {fb(misr), misr[15:1]} ^ {9'b0, cut_po}
    - pat_idx <= pat_idx + 1
  - fb(x) = x[0]^x[2]^x[3]^x[5], i.e. polynomial x^16+x^14+x^13+x^11+1.
  - The edge at which pat_idx reaches PAT_CNT moves to COMPARE.
- COMPARE:
  - One cycle; cut_pi = 0.
  - pass <= (misr == GOLDEN); then -> DONE.
- DONE:
  - done = 1, busy = 0; pass, signature and pat_idx hold; cut_pi = 0.
  - start=1 -> FLUSH, with the same initialisation as from IDLE.
- start while busy is ignored.
- abort (any non-IDLE state): next state IDLE; done = 0, pass = 0, cut_pi = 0; lfsr and misr keep their values until the next start.
- abort and start in the same cycle: abort wins, the block goes to IDLE, and start is ignored.
- RESET_N asserted mid-run: immediate return to the reset values, regardless of CLOCK.
- Overflow: pat_idx never exceeds PAT_CNT, so no wrap-around occurs.
- signature always mirrors the misr register.

Optional Feature:
- Macro: S386_BIST_PAUSE_EN.
- Defined:
  - Adds input port pause (1 bit).
  - While pause=1 in RUN: lfsr, misr and pat_idx are frozen; cut_pi holds its value; the state stays RUN.
  - pause in any other state has no effect.
  - abort overrides pause.
- Undefined: no pause port; RUN never stalls.

Test Plan:
- Reset, then start with defaults and cut_po=0 -> busy=1 for 8 FLUSH + 255 RUN + 1 COMPARE cycles (264 total); then done=1, pass=1, signature=16'h0000, pat_idx=255.
- LFSR sequence check -> cut_pi = 0 throughout FLUSH; first RUN cycle cut_pi=7'h61 (from 16'hACE1); second RUN cycle cut_pi=7'h70 (from 16'h5670).
- PAT_CNT=1, MISR_SEED=0, cut_po=7'h01 -> signature=16'h0001; with GOLDEN=0, pass=0.
- abort asserted at pat_idx=10 -> next cycle state IDLE, busy=0, done=0, cut_pi=0; a following start restarts with cut_pi=7'h61 after the flush.
- RESET_N pulsed low mid-RUN, asynchronously between edges -> all outputs return to reset values immediately; start asserted during FLUSH is ignored and the run length is unchanged.
- S386_BIST_PAUSE_EN defined: pause high for 5 cycles at pat_idx=20 -> pat_idx, signature and cut_pi are constant during the pause; final signature equals that of the unpaused run.

Source files
------------

// File: rtl/s386_bist_ctrl.sv
// s386_bist_ctrl: BIST sequencer for the s386w core (flush, LFSR patterns, MISR compaction, golden compare).
//   CLOCK, RESET_N (async, active-low); start/abort control;
//   cut_pi[6:0] -> core inputs, cut_po[6:0] <- core outputs;
//   busy/done/pass status, signature = MISR contents, pat_idx = patterns applied.
//   Optional `S386_BIST_PAUSE_EN adds input pause that stalls the RUN phase.
module s386_bist_ctrl #(
  parameter int unsigned PAT_CNT   = 255,
  parameter int unsigned FLUSH_CYC = 8,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter logic [15:0] MISR_SEED = 16'h0000,
  parameter logic [15:0] GOLDEN    = 16'h0000
) (
  input  logic        CLOCK,
  input  logic        RESET_N,
  input  logic        start,
  input  logic        abort,
`ifdef S386_BIST_PAUSE_EN
  input  logic        pause,
`endif
  output logic [6:0]  cut_pi,
  input  logic [6:0]  cut_po,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] signature,
  output logic [15:0] pat_idx
);
  typedef enum logic [2:0] {IDLE, FLUSH, RUN, COMPARE, DONE} state_t;
  state_t      state_q, state_d;
  logic [7:0]  fcnt_q, fcnt_d;
  logic [15:0] lfsr_q, lfsr_d, misr_q, misr_d, pat_q, pat_d;
  logic        pass_q, pass_d, stall;
`ifdef S386_BIST_PAUSE_EN
  assign stall = pause;
`else
  assign stall = 1'b0;
`endif
  always_ff @(posedge CLOCK or negedge RESET_N)
    if (!RESET_N) begin
      state_q <= IDLE;
      fcnt_q  <= '0;
      lfsr_q  <= LFSR_SEED;
      misr_q  <= MISR_SEED;
      pat_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      lfsr_q  <= lfsr_d;
      misr_q  <= misr_d;
      pat_q   <= pat_d;
      pass_q  <= pass_d;
    end
  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    lfsr_d  = lfsr_q;
    misr_d  = misr_q;
    pat_d   = pat_q;
    pass_d  = pass_q;
    // abort beats start and pause; lfsr/misr are left untouched until the next start
    if (abort && state_q != IDLE) begin
      state_d = IDLE;
      pass_d  = 1'b0;
    end else
      case (state_q)
        IDLE, DONE:
          if (start) begin
            state_d = FLUSH;
            fcnt_d  = 8'(FLUSH_CYC);
            lfsr_d  = LFSR_SEED;
            misr_d  = MISR_SEED;
            pat_d   = '0;
            pass_d  = 1'b0;
          end
        FLUSH: begin
          fcnt_d  = fcnt_q - 8'd1;
          state_d = fcnt_q == 8'd1 ? RUN : FLUSH;
        end
        RUN:
          if (!stall) begin
            lfsr_d  = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
            misr_d  = {misr_q[0] ^ misr_q[2] ^ misr_q[3] ^ misr_q[5], misr_q[15:1]} ^ {9'b0, cut_po};
            pat_d   = pat_q + 16'd1;
            state_d = pat_d == 16'(PAT_CNT) ? COMPARE : RUN;
          end
        COMPARE: begin
          pass_d  = misr_q == GOLDEN;
          state_d = DONE;
        end
        default: state_d = IDLE;
      endcase
  end
  // the core input is taken straight from the registered lfsr, so it holds whenever lfsr is frozen
  assign cut_pi    = state_q == RUN ? lfsr_q[6:0] : 7'd0;
  assign busy      = state_q == FLUSH || state_q == RUN || state_q == COMPARE;
  assign done      = state_q == DONE;
  assign pass      = pass_q;
  assign signature = misr_q;
  assign pat_idx   = pat_q;
endmodule

// File: tb/tb_s386_bist_ctrl.sv
// tb_s386_bist_ctrl: randomized self-checking bench for s386_bist_ctrl against a table-driven core model.
module tb_s386_bist_ctrl;
  logic        CLOCK = 1'b0, RESET_N = 1'b0, start = 1'b0, abort = 1'b0, pause = 1'b0;
  logic [6:0]  cut_pi, cut_po;
  logic        busy, done, pass;
  logic [15:0] signature, pat_idx;
  logic        start_one = 1'b0;
  logic [6:0]  cut_pi_one;
  logic        busy_one, done_one, pass_one;
  logic [15:0] signature_one, pat_idx_one;
  logic        use_tbl = 1'b0;
  logic [6:0]  tbl [0:127];
  logic [6:0]  exp_pi [0:255];
  logic [15:0] exp_sig [0:255];
  int total = 0, bad = 0;

  always #5 CLOCK = ~CLOCK;
  // stand-in combinational core: a random truth table from inputs to outputs
  assign cut_po = use_tbl ? tbl[cut_pi] : 7'h00;

  s386_bist_ctrl u_dut (
    .CLOCK(CLOCK), .RESET_N(RESET_N), .start(start), .abort(abort),
`ifdef S386_BIST_PAUSE_EN
    .pause(pause),
`endif
    .cut_pi(cut_pi), .cut_po(cut_po), .busy(busy), .done(done), .pass(pass),
    .signature(signature), .pat_idx(pat_idx));

  s386_bist_ctrl #(.PAT_CNT(1), .FLUSH_CYC(2)) u_one (
    .CLOCK(CLOCK), .RESET_N(RESET_N), .start(start_one), .abort(1'b0),
`ifdef S386_BIST_PAUSE_EN
    .pause(1'b0),
`endif
    .cut_pi(cut_pi_one), .cut_po(7'h01), .busy(busy_one), .done(done_one), .pass(pass_one),
    .signature(signature_one), .pat_idx(pat_idx_one));

  // expected core inputs and signatures after i patterns, from the polynomial x^16+x^14+x^13+x^11+1
  function automatic void fill_model(input bit rnd);
    logic [15:0] l, m;
    logic [6:0] po;
    use_tbl = rnd;
    for (int i = 0; i < 128; i++) tbl[i] = 7'($urandom);
    l = 16'hACE1;
    m = 16'h0000;
    for (int i = 0; i <= 255; i++) begin
      exp_pi[i]  = l[6:0];
      exp_sig[i] = m;
      po = rnd ? tbl[l[6:0]] : 7'h00;
      m = {^(m & 16'h002D), m[15:1]} ^ {9'b0, po};
      l = {^(l & 16'h002D), l[15:1]};
    end
  endfunction

  task automatic test_reset;
    #12;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0h exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%0h exp=0", done); end
    total++; if (pass !== 1'b0) begin bad++; $display("FAIL reset_pass got=%0h exp=0", pass); end
    total++; if (cut_pi !== 7'h00) begin bad++; $display("FAIL reset_cut_pi got=%0h exp=0", cut_pi); end
    total++; if (signature !== 16'h0000) begin bad++; $display("FAIL reset_sig got=%0h exp=0", signature); end
    total++; if (pat_idx !== 16'h0000) begin bad++; $display("FAIL reset_pat_idx got=%0h exp=0", pat_idx); end
    @(negedge CLOCK) RESET_N = 1'b1;
  endtask

  task automatic test_run(input bit rnd, input bit hold_start, input int pause_at);
    int k, cyc, paused;
    logic [6:0] e_pi;
    fill_model(rnd);
    @(negedge CLOCK) start = 1'b1;
    @(negedge CLOCK);
    if (!hold_start) start = 1'b0;
    k = 0; cyc = 0; paused = 0;
    while (busy === 1'b1 && cyc < 600) begin
      e_pi = (k >= 8 && k < 263) ? exp_pi[k-8] : 7'h00;
      total++; if (cut_pi !== e_pi) begin bad++; $display("FAIL run_cut_pi k=%0d got=%0h exp=%0h", k, cut_pi, e_pi); end
      if (k == 8) begin total++; if (cut_pi !== 7'h61) begin bad++; $display("FAIL first_pat got=%0h exp=61", cut_pi); end end
      if (k == 9) begin total++; if (cut_pi !== 7'h70) begin bad++; $display("FAIL second_pat got=%0h exp=70", cut_pi); end end
      if (k >= 8 && k < 263) begin
        total++; if (pat_idx !== 16'(k-8)) begin bad++; $display("FAIL run_pat_idx got=%0d exp=%0d", pat_idx, k-8); end
        total++; if (signature !== exp_sig[k-8]) begin bad++; $display("FAIL run_sig k=%0d got=%0h exp=%0h", k, signature, exp_sig[k-8]); end
      end
      if (pause_at >= 0 && k == 8 + pause_at && paused < 5) begin
        pause = 1'b1;
        paused++;
      end else begin
        pause = 1'b0;
        k++;
      end
      if (k == 4) start = 1'b0;
      @(negedge CLOCK);
      cyc++;
    end
    start = 1'b0;
    pause = 1'b0;
    total++; if (k !== 264) begin bad++; $display("FAIL busy_len got=%0d exp=264", k); end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL done got=%0h exp=1", done); end
    total++; if (pass !== (exp_sig[255] == 16'h0000)) begin bad++; $display("FAIL pass got=%0h exp=%0h", pass, exp_sig[255] == 16'h0000); end
    total++; if (signature !== exp_sig[255]) begin bad++; $display("FAIL final_sig got=%0h exp=%0h", signature, exp_sig[255]); end
    total++; if (pat_idx !== 16'd255) begin bad++; $display("FAIL final_pat_idx got=%0d exp=255", pat_idx); end
    total++; if (cut_pi !== 7'h00) begin bad++; $display("FAIL done_cut_pi got=%0h exp=0", cut_pi); end
    @(negedge CLOCK);
    total++; if (done !== 1'b1 || signature !== exp_sig[255]) begin bad++; $display("FAIL done_hold got=%0h/%0h exp=1/%0h", done, signature, exp_sig[255]); end
  endtask

  task automatic test_pat1;
    int cyc;
    @(negedge CLOCK) start_one = 1'b1;
    @(negedge CLOCK) start_one = 1'b0;
    cyc = 0;
    while (done_one !== 1'b1 && cyc < 20) begin @(negedge CLOCK); cyc++; end
    total++; if (done_one !== 1'b1) begin bad++; $display("FAIL pat1_done got=%0h exp=1", done_one); end
    total++; if (signature_one !== 16'h0001) begin bad++; $display("FAIL pat1_sig got=%0h exp=0001", signature_one); end
    total++; if (pass_one !== 1'b0) begin bad++; $display("FAIL pat1_pass got=%0h exp=0", pass_one); end
    total++; if (pat_idx_one !== 16'd1) begin bad++; $display("FAIL pat1_pat_idx got=%0d exp=1", pat_idx_one); end
  endtask

  task automatic test_abort;
    int cyc;
    fill_model(1'b1);
    @(negedge CLOCK) start = 1'b1;
    @(negedge CLOCK) start = 1'b0;
    cyc = 0;
    while (!(busy === 1'b1 && cut_pi !== 7'h00 && pat_idx === 16'd10) && cyc < 100) begin @(negedge CLOCK); cyc++; end
    total++; if (pat_idx !== 16'd10) begin bad++; $display("FAIL abort_reach got=%0d exp=10", pat_idx); end
    abort = 1'b1;
    start = 1'b1;
    @(negedge CLOCK);
    abort = 1'b0;
    start = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%0h exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL abort_done got=%0h exp=0", done); end
    total++; if (pass !== 1'b0) begin bad++; $display("FAIL abort_pass got=%0h exp=0", pass); end
    total++; if (cut_pi !== 7'h00) begin bad++; $display("FAIL abort_cut_pi got=%0h exp=0", cut_pi); end
    total++; if (signature !== exp_sig[10]) begin bad++; $display("FAIL abort_sig got=%0h exp=%0h", signature, exp_sig[10]); end
    @(negedge CLOCK);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_idle got=%0h exp=0", busy); end
    test_run(1'b1, 1'b0, -1);
  endtask

  task automatic test_reset_mid;
    int cyc;
    fill_model(1'b1);
    @(negedge CLOCK) start = 1'b1;
    @(negedge CLOCK) start = 1'b0;
    cyc = 0;
    while (pat_idx !== 16'd30 && cyc < 100) begin @(negedge CLOCK); cyc++; end
    @(posedge CLOCK);
    #2 RESET_N = 1'b0;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0h exp=0", busy); end
    total++; if (cut_pi !== 7'h00) begin bad++; $display("FAIL rst_cut_pi got=%0h exp=0", cut_pi); end
    total++; if (signature !== 16'h0000) begin bad++; $display("FAIL rst_sig got=%0h exp=0", signature); end
    total++; if (pat_idx !== 16'h0000) begin bad++; $display("FAIL rst_pat_idx got=%0h exp=0", pat_idx); end
    total++; if (done !== 1'b0 || pass !== 1'b0) begin bad++; $display("FAIL rst_done_pass got=%0h%0h exp=00", done, pass); end
    @(negedge CLOCK) RESET_N = 1'b1;
    test_run(1'b1, 1'b1, -1);
  endtask

  initial begin
    test_reset;
    test_run(1'b0, 1'b0, -1);
    test_run(1'b1, 1'b0, -1);
    test_pat1;
    test_abort;
    test_reset_mid;
`ifdef S386_BIST_PAUSE_EN
    test_run(1'b1, 1'b0, 20);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
